uart_block_serializer: RTL and testbench

- Sits between the decryption output stage (mu multiplier / final mod) and uart_transmit.
- Accepts a stream of REGISTER_SIZE-bit result blocks, least-significant block first.
- Buffers the blocks in a circular FIFO and emits every byte of every block, LSB-first, to uart_transmit using its trigger/busy handshake.
- Replaces the current direct hookup, which sends only bits [7:0] of each block.

---
 rtl/uart_block_serializer.sv | 191 +++++++++++++++++++
 tb/tb_uart_block_serializer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_block_serializer.sv
// Buffers wide result blocks in a circular FIFO and feeds them to uart_transmit
// one byte at a time, least-significant byte first, using its trigger/busy handshake.
module uart_block_serializer #(
    parameter int REGISTER_SIZE = 32,
    parameter int DEPTH         = 64
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [REGISTER_SIZE-1:0] block_in,
    input  logic                     valid_in,
    input  logic                     final_in,
    input  logic                     tx_busy_in,
    output logic [7:0]               byte_out,
    output logic                     trigger_out,
    output logic                     ready_out,
    output logic                     overflow_out,
    output logic                     done_out
);

    localparam int BYTES = REGISTER_SIZE / 8;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND       = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

    logic [REGISTER_SIZE:0]   mem_r [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_r;
    logic [PTR_W-1:0]         rd_ptr_r;
    logic [CNT_W-1:0]         count_r;
    logic [CNT_W-1:0]         count_nx_s;
    logic                     ready_r;
    logic                     overflow_r;

    state_t                   state_r;
    state_t                   state_nx_s;
    logic [REGISTER_SIZE-1:0] sh_r;
    logic [REGISTER_SIZE-1:0] sh_nx_s;
    logic [IDX_W-1:0]         idx_r;
    logic [IDX_W-1:0]         idx_nx_s;
    logic                     fin_r;
    logic                     fin_nx_s;
    logic [7:0]               byte_r;
    logic [7:0]               byte_nx_s;
    logic                     trigger_r;
    logic                     trigger_nx_s;
    logic                     done_r;
    logic                     done_nx_s;

    logic                     pop_s;
    logic                     push_s;
    logic                     drop_s;
    logic [REGISTER_SIZE:0]   head_s;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write then.
    assign pop_s  = (state_r == IDLE) && (count_r != '0);
    assign push_s = valid_in && ((count_r != DEPTH_C) || pop_s);
    assign drop_s = valid_in && !push_s;
    assign head_s = mem_r[rd_ptr_r];

    // Occupancy update from the push/pop pair
    always_comb begin
        count_nx_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nx_s = count_r + CNT_W'(1);
            2'b01:   count_nx_s = count_r - CNT_W'(1);
            default: count_nx_s = count_r;
        endcase
    end

    // Block storage: entry holds the final flag above the block data
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {final_in, block_in};
        end
    end

    // FIFO pointers, occupancy, registered ready and sticky overflow
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            ready_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nx_s;
            ready_r <= (count_nx_s != DEPTH_C);
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Byte sequencer: next state and next registered outputs
    always_comb begin
        state_nx_s   = state_r;
        sh_nx_s      = sh_r;
        idx_nx_s     = idx_r;
        fin_nx_s     = fin_r;
        byte_nx_s    = byte_r;
        trigger_nx_s = 1'b0;
        done_nx_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (pop_s) begin
                    sh_nx_s    = head_s[REGISTER_SIZE-1:0];
                    fin_nx_s   = head_s[REGISTER_SIZE];
                    idx_nx_s   = '0;
                    state_nx_s = SEND;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SEND: begin
                if (!tx_busy_in) begin
                    trigger_nx_s = 1'b1;
                    byte_nx_s    = sh_r[7:0];
                    state_nx_s   = WAIT_START;
                end else begin
                    state_nx_s = SEND;
                end
            end
            WAIT_START: begin
                if (tx_busy_in) begin
                    state_nx_s = WAIT_DONE;
                end else begin
                    state_nx_s = WAIT_START;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy_in) begin
                    if (idx_r == LAST_IDX) begin
                        done_nx_s  = fin_r;
                        state_nx_s = IDLE;
                    end else begin
                        sh_nx_s    = sh_r >> 4'd8;
                        idx_nx_s   = idx_r + IDX_W'(1);
                        state_nx_s = SEND;
                    end
                end else begin
                    state_nx_s = WAIT_DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Sequencer state and output registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r   <= IDLE;
            sh_r      <= '0;
            idx_r     <= '0;
            fin_r     <= 1'b0;
            byte_r    <= 8'h00;
            trigger_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            sh_r      <= sh_nx_s;
            idx_r     <= idx_nx_s;
            fin_r     <= fin_nx_s;
            byte_r    <= byte_nx_s;
            trigger_r <= trigger_nx_s;
            done_r    <= done_nx_s;
        end
    end

    assign byte_out     = byte_r;
    assign trigger_out  = trigger_r;
    assign ready_out    = ready_r;
    assign overflow_out = overflow_r;
    assign done_out     = done_r;

endmodule

// File: tb/tb_uart_block_serializer.sv
// Directed bench: a DEPTH=64 and a DEPTH=4 serializer, each driving a simple
// uart_transmit model that raises busy the cycle after trigger for len cycles.
`timescale 1ns/1ps
module tb_uart_block_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] blk_a = 32'h0, blk_b = 32'h0;
    logic        vld_a = 1'b0, vld_b = 1'b0;
    logic        fin_a = 1'b0, fin_b = 1'b0;
    logic        hold_a = 1'b0, hold_b = 1'b0;
    logic        busy_a, busy_b;
    int          len_a = 10, len_b = 3;
    int          cnt_a, cnt_b;

    logic [7:0]  byte_a, byte_b;
    logic        trig_a, trig_b, rdy_a, rdy_b, ovf_a, ovf_b, done_a, done_b;

    logic [7:0]  cap_a [0:1023];
    logic [7:0]  cap_b [0:1023];
    int          ncap_a = 0, ncap_b = 0;
    int          ndone_a = 0, nfall_a = 0, done_fall_a = 0, done_trig_a = 0;
    logic        dbl_a = 1'b0, dbl_b = 1'b0;
    logic        prev_trig_a = 1'b0, prev_trig_b = 1'b0, prev_busy_a = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_block_serializer #(.REGISTER_SIZE(32), .DEPTH(64)) u_dut_a (
        .clk_in(clk), .rst_in(rst), .block_in(blk_a), .valid_in(vld_a),
        .final_in(fin_a), .tx_busy_in(busy_a), .byte_out(byte_a),
        .trigger_out(trig_a), .ready_out(rdy_a), .overflow_out(ovf_a),
        .done_out(done_a)
    );

    uart_block_serializer #(.REGISTER_SIZE(32), .DEPTH(4)) u_dut_b (
        .clk_in(clk), .rst_in(rst), .block_in(blk_b), .valid_in(vld_b),
        .final_in(fin_b), .tx_busy_in(busy_b), .byte_out(byte_b),
        .trigger_out(trig_b), .ready_out(rdy_b), .overflow_out(ovf_b),
        .done_out(done_b)
    );

    assign busy_a = hold_a | (cnt_a != 0);
    assign busy_b = hold_b | (cnt_b != 0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a <= 0;
            cnt_b <= 0;
        end else begin
            if (trig_a) cnt_a <= len_a;
            else if (cnt_a != 0) cnt_a <= cnt_a - 1;
            if (trig_b) cnt_b <= len_b;
            else if (cnt_b != 0) cnt_b <= cnt_b - 1;
        end
    end

    // Monitors sample mid-cycle and only accumulate; tasks snapshot and compare.
    always @(negedge clk) begin
        if (trig_a) begin
            cap_a[ncap_a] <= byte_a;
            ncap_a <= ncap_a + 1;
        end
        dbl_a <= dbl_a | (trig_a & prev_trig_a);
        prev_trig_a <= trig_a;
        if (prev_busy_a && !busy_a) nfall_a <= nfall_a + 1;
        prev_busy_a <= busy_a;
        if (done_a) begin
            ndone_a <= ndone_a + 1;
            done_fall_a <= nfall_a;
            done_trig_a <= ncap_a;
        end
        if (trig_b) begin
            cap_b[ncap_b] <= byte_b;
            ncap_b <= ncap_b + 1;
        end
        dbl_b <= dbl_b | (trig_b & prev_trig_b);
        prev_trig_b <= trig_b;
    end

    task automatic test_reset();
        #12;
        checks++;
        if ({byte_a, trig_a, rdy_a, ovf_a, done_a} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_a: got byte=%h trig=%b rdy=%b ovf=%b done=%b expected 00 0 1 0 0",
                     byte_a, trig_a, rdy_a, ovf_a, done_a);
        end
        checks++;
        if ({byte_b, trig_b, rdy_b, ovf_b, done_b} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_b: got byte=%h trig=%b rdy=%b ovf=%b done=%b expected 00 0 1 0 0",
                     byte_b, trig_b, rdy_b, ovf_b, done_b);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_block();
        int cb, db, fb;
        logic [7:0] exp_b [4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        len_a = 10;
        @(negedge clk);
        cb = ncap_a; db = ndone_a; fb = nfall_a;
        blk_a = 32'h44332211; fin_a = 1'b1; vld_a = 1'b1;
        @(negedge clk);
        vld_a = 1'b0; fin_a = 1'b0;
        checks++;
        if (trig_a !== 1'b0) begin errors++; $display("FAIL lat_t1: got trig=%b expected 0", trig_a); end
        @(negedge clk);
        checks++;
        if (trig_a !== 1'b0) begin errors++; $display("FAIL lat_t2: got trig=%b expected 0", trig_a); end
        @(negedge clk);
        checks++;
        if ({trig_a, byte_a} !== {1'b1, 8'h11}) begin
            errors++;
            $display("FAIL lat_t3: got trig=%b byte=%h expected 1 11", trig_a, byte_a);
        end
        for (int i = 0; i < 400 && ndone_a == db; i++) @(posedge clk);
        checks++;
        if (ndone_a == db) begin errors++; $display("FAIL single_done_timeout: got no done expected done"); end
        repeat (20) @(posedge clk);
        checks++;
        if (ncap_a - cb !== 4) begin errors++; $display("FAIL single_trigs: got %0d expected 4", ncap_a - cb); end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (cap_a[cb + j] !== exp_b[j]) begin
                errors++;
                $display("FAIL single_byte%0d: got %h expected %h", j, cap_a[cb + j], exp_b[j]);
            end
        end
        checks++;
        if (ndone_a - db !== 1) begin errors++; $display("FAIL single_done_cnt: got %0d expected 1", ndone_a - db); end
        checks++;
        if (done_fall_a - fb !== 4) begin errors++; $display("FAIL single_done_after_fall: got %0d expected 4", done_fall_a - fb); end
        checks++;
        if (done_trig_a - cb !== 4) begin errors++; $display("FAIL single_done_after_trig: got %0d expected 4", done_trig_a - cb); end
    endtask

    task automatic test_busy_stall();
        int cb;
        logic [7:0] exp_b [4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        len_a = 10;
        @(negedge clk);
        hold_a = 1'b1;
        cb = ncap_a;
        blk_a = 32'h44332211; vld_a = 1'b1;
        @(negedge clk);
        vld_a = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ncap_a - cb !== 0) begin errors++; $display("FAIL stall_no_trig: got %0d expected 0", ncap_a - cb); end
        hold_a = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({trig_a, byte_a} !== {1'b1, 8'h11}) begin
            errors++;
            $display("FAIL stall_release: got trig=%b byte=%h expected 1 11", trig_a, byte_a);
        end
        for (int i = 0; i < 400 && (ncap_a - cb) < 4; i++) @(posedge clk);
        repeat (20) @(posedge clk);
        checks++;
        if (ncap_a - cb !== 4) begin errors++; $display("FAIL stall_trigs: got %0d expected 4", ncap_a - cb); end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (cap_a[cb + j] !== exp_b[j]) begin
                errors++;
                $display("FAIL stall_byte%0d: got %h expected %h", j, cap_a[cb + j], exp_b[j]);
            end
        end
    endtask

    task automatic test_burst64();
        int cb, db, bad, first;
        len_a = 2;
        @(negedge clk);
        cb = ncap_a; db = ndone_a;
        for (int k = 0; k < 64; k++) begin
            blk_a = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            fin_a = (k == 63);
            vld_a = 1'b1;
            @(negedge clk);
        end
        vld_a = 1'b0; fin_a = 1'b0;
        checks++;
        if ({rdy_a, ovf_a} !== 2'b10) begin errors++; $display("FAIL burst_flags: got rdy=%b ovf=%b expected 1 0", rdy_a, ovf_a); end
        for (int i = 0; i < 5000 && ndone_a == db; i++) @(posedge clk);
        repeat (20) @(posedge clk);
        checks++;
        if (ncap_a - cb !== 256) begin errors++; $display("FAIL burst_count: got %0d expected 256", ncap_a - cb); end
        bad = 0; first = -1;
        for (int j = 0; j < 256; j++) begin
            if (cap_a[cb + j] !== 8'(j)) begin
                bad++;
                if (first < 0) first = j;
            end
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL burst_order: got %0d bad bytes (first at %0d) expected 0", bad, first); end
        checks++;
        if (ndone_a - db !== 1) begin errors++; $display("FAIL burst_done: got %0d expected 1", ndone_a - db); end
        checks++;
        if (done_trig_a - cb !== 256) begin errors++; $display("FAIL burst_done_pos: got %0d expected 256", done_trig_a - cb); end
        checks++;
        if (ovf_a !== 1'b0) begin errors++; $display("FAIL burst_ovf: got %b expected 0", ovf_a); end
    endtask

    task automatic test_reset_mid();
        int cb, db;
        len_a = 10;
        @(negedge clk);
        cb = ncap_a;
        blk_a = 32'h44332211; vld_a = 1'b1;
        @(negedge clk);
        blk_a = 32'h88776655; fin_a = 1'b1;
        @(negedge clk);
        vld_a = 1'b0; fin_a = 1'b0;
        for (int i = 0; i < 200 && (ncap_a - cb) < 2; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        checks++;
        if ({busy_a, byte_a} !== {1'b1, 8'h22}) begin
            errors++;
            $display("FAIL mid_pre: got busy=%b byte=%h expected 1 22", busy_a, byte_a);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({byte_a, trig_a, rdy_a, ovf_a, done_a} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got byte=%h trig=%b rdy=%b ovf=%b done=%b expected 00 0 1 0 0",
                     byte_a, trig_a, rdy_a, ovf_a, done_a);
        end
        @(negedge clk);
        rst = 1'b0;
        cb = ncap_a; db = ndone_a;
        repeat (30) @(posedge clk);
        checks++;
        if (ncap_a - cb !== 0) begin errors++; $display("FAIL mid_fifo_empty: got %0d trigs expected 0", ncap_a - cb); end
        @(negedge clk);
        blk_a = 32'hA5A5A5A5; fin_a = 1'b1; vld_a = 1'b1;
        @(negedge clk);
        vld_a = 1'b0; fin_a = 1'b0;
        for (int i = 0; i < 400 && ndone_a == db; i++) @(posedge clk);
        repeat (30) @(posedge clk);
        checks++;
        if (ncap_a - cb !== 4) begin errors++; $display("FAIL mid_new_count: got %0d expected 4", ncap_a - cb); end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (cap_a[cb + j] !== 8'hA5) begin
                errors++;
                $display("FAIL mid_new_byte%0d: got %h expected a5", j, cap_a[cb + j]);
            end
        end
        checks++;
        if (ndone_a - db !== 1) begin errors++; $display("FAIL mid_new_done: got %0d expected 1", ndone_a - db); end
    endtask

    // The head block leaves the FIFO for the shift register at once, so with
    // busy held the fifth write fills the FIFO and the sixth is dropped.
    task automatic test_overflow();
        int cb, bad;
        logic [7:0] exp;
        len_b = 3;
        @(negedge clk);
        hold_b = 1'b1;
        cb = ncap_b;
        for (int k = 0; k < 6; k++) begin
            blk_b = 32'(k); vld_b = 1'b1;
            @(negedge clk);
            checks++;
            if ({rdy_b, ovf_b} !== {(k < 4) ? 1'b1 : 1'b0, (k == 5) ? 1'b1 : 1'b0}) begin
                errors++;
                $display("FAIL ovf_write%0d: got rdy=%b ovf=%b expected %b %b", k, rdy_b, ovf_b,
                         (k < 4) ? 1'b1 : 1'b0, (k == 5) ? 1'b1 : 1'b0);
            end
        end
        vld_b = 1'b0;
        hold_b = 1'b0;
        for (int i = 0; i < 1000 && (ncap_b - cb) < 20; i++) @(posedge clk);
        repeat (60) @(posedge clk);
        checks++;
        if (ncap_b - cb !== 20) begin errors++; $display("FAIL ovf_count: got %0d expected 20", ncap_b - cb); end
        bad = 0;
        for (int j = 0; j < 20; j++) begin
            exp = ((j % 4) == 0) ? 8'(j / 4) : 8'h00;
            if (cap_b[cb + j] !== exp) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL ovf_order: got %0d bad bytes expected 0", bad); end
        checks++;
        if ({rdy_b, ovf_b} !== 2'b11) begin errors++; $display("FAIL ovf_sticky: got rdy=%b ovf=%b expected 1 1", rdy_b, ovf_b); end
    endtask

    task automatic test_wrap();
        int cb, bad;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ovf_b !== 1'b0) begin errors++; $display("FAIL wrap_ovf_cleared: got %b expected 0", ovf_b); end
        len_b = 3;
        cb = ncap_b;
        for (int k = 0; k < 10; k++) begin
            blk_b = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            vld_b = 1'b1;
            @(negedge clk);
            vld_b = 1'b0;
            repeat (29) @(negedge clk);
        end
        for (int i = 0; i < 1000 && (ncap_b - cb) < 40; i++) @(posedge clk);
        repeat (40) @(posedge clk);
        checks++;
        if (ncap_b - cb !== 40) begin errors++; $display("FAIL wrap_count: got %0d expected 40", ncap_b - cb); end
        bad = 0;
        for (int j = 0; j < 40; j++) begin
            if (cap_b[cb + j] !== 8'(j)) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL wrap_order: got %0d bad bytes expected 0", bad); end
        checks++;
        if (ovf_b !== 1'b0) begin errors++; $display("FAIL wrap_ovf: got %b expected 0", ovf_b); end
        checks++;
        if ({dbl_a, dbl_b} !== 2'b00) begin
            errors++;
            $display("FAIL double_trigger: got a=%b b=%b expected 0 0", dbl_a, dbl_b);
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_busy_stall();
        test_burst64();
        test_reset_mid();
        test_overflow();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
